renode_ahb_subordinate_pipe: RTL and testbench
==============================================

// Module: renode_ahb_subordinate_pipe
// PURPOSE
//  Parametrised, synthesizable AHB-Lite subordinate front-end with a pipelined address/data phase.
//  Posts writes into a WBUF_DEPTH FIFO and drains them to a generic valid/ready backend port.
//  Stalls reads until the FIFO is empty, then fetches the read data from the backend.
//  Generates HSIZE byte strobes and the two-cycle AHB ERROR response.
//  Sits between an AHB manager and a Renode-side or RTL memory/peripheral backend.
// PARAMETERS
//  ADDR_WIDTH   32  HADDR/req_addr width
//  DATA_WIDTH   32  HWDATA/HRDATA width; 32 or 64 (STRB_W = DATA_WIDTH/8)
//  WBUF_DEPTH   4   posted-write FIFO entries; power of 2, >=2
// PORTS
//  HCLK        in   1          clock
//  HRESET      in   1          synchronous, active-high reset
//  HSEL        in   1          subordinate select
//  HADDR       in   ADDR_WIDTH address
//  HTRANS      in   2          0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
//  HWRITE      in   1          1 = write
//  HSIZE       in   3          log2 bytes per beat
//  HWDATA      in   DATA_WIDTH write data (data phase)
//  HREADY      in   1          bus-level ready
//  HREADYOUT   out  1          subordinate ready
//  HRESP       out  1          0 OKAY, 1 ERROR
//  HRDATA      out  DATA_WIDTH read data
//  req_valid   out  1          backend request valid; held stable until req_ready
//  req_ready   in   1          backend accepts the request
//  req_write   out  1          1 = write request
//  req_addr    out  ADDR_WIDTH beat address, aligned down to 2^HSIZE
//  req_wdata   out  DATA_WIDTH write data
//  req_strb    out  STRB_W     byte enables
//  rsp_valid   in   1          backend response; >=1 cycle after the request is accepted
//  rsp_rdata   in   DATA_WIDTH read data
//  rsp_error   in   1          backend error
//  wr_error    out  1          1-cycle pulse on a posted-write error response
//  wbuf_level  out  $clog2(WBUF_DEPTH+1)  FIFO occupancy
// BEHAVIOUR
//  Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, req_valid=0, req_*=0, wr_error=0, wbuf_level=0.
//  Reset mid-transfer: FIFO flushed (posted writes lost), FSMs return to IDLE; rsp_valid ignored until the next request.
//  Accept a beat when HSEL & HREADY & HTRANS[1]. IDLE/BUSY/unselected beats: HREADYOUT=1, HRESP=0.
//  req_strb: ((1<<(1<<HSIZE))-1) << (HADDR[log2 STRB_W-1:0] & ~((1<<HSIZE)-1)).
//  HSIZE > log2 STRB_W: all strobes set.
//  Bus FSM states: IDLE, WDATA, RD_DRAIN, RD_REQ, RD_WAIT, ERR1, ERR2.
//   IDLE -> WDATA on an accepted write; -> RD_DRAIN on an accepted read.
//   WDATA: capture HWDATA and push {addr,data,strb} when the FIFO is not full, with HREADYOUT=1.
//     A new accepted beat in the same cycle is pipelined, giving 1 write/cycle.
//     FIFO full: HREADYOUT=0 until a pop frees a slot; push in that cycle.
//   RD_DRAIN: HREADYOUT=0 until the FIFO is empty and the backend engine is idle (reads never bypass writes).
//   RD_REQ: drive read request; on handshake -> RD_WAIT.
//   RD_WAIT: on rsp_valid: OKAY -> HRDATA=rsp_rdata, HREADYOUT=1, -> IDLE; error -> ERR1.
//   ERR1: HREADYOUT=0, HRESP=1. ERR2: HREADYOUT=1, HRESP=1.
//     ERR2 -> IDLE; a beat accepted in ERR2 is processed normally.
//  Backend engine, one outstanding request: BE_IDLE -> BE_REQ (FIFO head or read) -> BE_WAIT -> BE_IDLE on rsp_valid.
//   Pop the FIFO on the write req handshake. A write rsp_error pulses wr_error; the bus sees OKAY (posted).
//  Simultaneous push and pop on the same cycle: level unchanged. Full-level push is never lost (bus stalls).
//  Read latency: drain + 1 (req) + backend latency + 1 cycles of HREADYOUT=0 minimum.
// CONFIGURATION
//  RENODE_AHB_ALIGN_CHECK_EN defined: misaligned beats (HADDR mod 2^HSIZE != 0) or HSIZE > log2 STRB_W
//   get ERR1/ERR2 with no backend access and no FIFO push (write data discarded).
//  Undefined: no check; address aligned down silently, oversize uses full strobes.
// TESTING
//  1 Reset held 3 cycles mid-read -> HREADYOUT=1, HRESP=0, req_valid=0, wbuf_level=0; next read completes normally.
//  2 4 back-to-back NONSEQ word writes to 0x100..0x10C, req_ready=0 (DEPTH=4)
//    -> zero wait states, wbuf_level=4.
//    5th write stalls HREADYOUT=0 until req_ready=1.
//  3 Write 0x100=0xDEADBEEF then read 0x100 -> read waits for the FIFO to drain.
//    Req order is write then read; HRDATA=backend data, HRESP=0.
//  4 Read with rsp_error=1 -> ERR1 (HREADYOUT=0,HRESP=1) then ERR2 (HREADYOUT=1,HRESP=1); next beat OKAY.
//  5 Byte write HSIZE=0 at 0x103 (DW=32) -> req_strb=4'b1000, req_addr=0x103.
//    Halfword at 0x102 -> strb 4'b1100.
//  6 ALIGN_CHECK_EN: word write at 0x102 -> ERROR pair, no req_valid.
//    Without the macro -> req_addr=0x100, strb 4'b1111.

Source files
------------

// File: rtl/renode_ahb_subordinate_pipe.sv
// renode_ahb_subordinate_pipe
// AHB-Lite subordinate front-end with a pipelined address/data phase. Writes are
// posted into a small FIFO and drained to a valid/ready backend port; reads wait
// until every posted write has completed, then fetch their data from the backend.
// HSIZE/HADDR are turned into byte strobes, and errors use the two-cycle ERROR
// response.
// Optional feature: define RENODE_AHB_ALIGN_CHECK_EN to answer misaligned or
// oversize beats with ERROR instead of silently aligning them.
module renode_ahb_subordinate_pipe #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int WBUF_DEPTH = 4
) (
  input  logic                              HCLK,
  input  logic                              HRESET,
  input  logic                              HSEL,
  input  logic [ADDR_WIDTH-1:0]             HADDR,
  input  logic [1:0]                        HTRANS,
  input  logic                              HWRITE,
  input  logic [2:0]                        HSIZE,
  input  logic [DATA_WIDTH-1:0]             HWDATA,
  input  logic                              HREADY,
  output logic                              HREADYOUT,
  output logic                              HRESP,
  output logic [DATA_WIDTH-1:0]             HRDATA,
  output logic                              req_valid,
  input  logic                              req_ready,
  output logic                              req_write,
  output logic [ADDR_WIDTH-1:0]             req_addr,
  output logic [DATA_WIDTH-1:0]             req_wdata,
  output logic [DATA_WIDTH/8-1:0]           req_strb,
  input  logic                              rsp_valid,
  input  logic [DATA_WIDTH-1:0]             rsp_rdata,
  input  logic                              rsp_error,
  output logic                              wr_error,
  output logic [$clog2(WBUF_DEPTH+1)-1:0]   wbuf_level
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int PTR_W  = $clog2(WBUF_DEPTH);
  localparam int LVL_W  = $clog2(WBUF_DEPTH + 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WDATA    = 3'd1;
  localparam logic [2:0] S_RD_DRAIN = 3'd2;
  localparam logic [2:0] S_RD_REQ   = 3'd3;
  localparam logic [2:0] S_RD_WAIT  = 3'd4;
  localparam logic [2:0] S_ERR1     = 3'd5;
  localparam logic [2:0] S_ERR2     = 3'd6;

  localparam logic [1:0] BE_IDLE = 2'd0;
  localparam logic [1:0] BE_REQ  = 2'd1;
  localparam logic [1:0] BE_WAIT = 2'd2;

  logic [2:0]            bus_state;
  logic [1:0]            be_state;

  logic [ADDR_WIDTH-1:0] size_mask;
  logic                  oversize;
  logic [STRB_W-1:0]     lane_mask;
  logic [STRB_W-1:0]     beat_strb;
  logic [ADDR_WIDTH-1:0] beat_addr;
  logic                  beat_bad;
  logic                  take_beat;

  logic [ADDR_WIDTH-1:0] ph_addr;
  logic [STRB_W-1:0]     ph_strb;

  logic [ADDR_WIDTH-1:0] fifo_addr [WBUF_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data [WBUF_DEPTH];
  logic [STRB_W-1:0]     fifo_strb [WBUF_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic                  can_push;

  logic                  unused_htrans0;

  assign unused_htrans0 = HTRANS[0];

  assign fifo_full  = (wbuf_level == LVL_W'(WBUF_DEPTH));
  assign fifo_empty = (wbuf_level == '0);
  assign pop        = (be_state == BE_REQ) && req_ready && req_write;
  assign can_push   = !fifo_full || pop;
  assign push       = (bus_state == S_WDATA) && can_push;
  assign take_beat  = HSEL && HREADY && HTRANS[1] && HREADYOUT;

  // Decode the live address phase into an aligned address and byte-lane strobes
  always_comb begin
    size_mask = '0;
    for (int b = 0; b < ADDR_WIDTH; b++) size_mask[b] = (b < int'(HSIZE));
    oversize = (int'(HSIZE) > OFF_W);
    lane_mask = '0;
    for (int i = 0; i < STRB_W; i++) lane_mask[i] = oversize || (i < (1 << int'(HSIZE)));
    beat_strb = lane_mask << (HADDR[OFF_W-1:0] & ~size_mask[OFF_W-1:0]);
    beat_addr = HADDR & ~size_mask;
  end

`ifdef RENODE_AHB_ALIGN_CHECK_EN
  assign beat_bad = oversize || (|(HADDR & size_mask));
`else
  assign beat_bad = 1'b0;
`endif

  // Bus-side handshake outputs follow the bus FSM; a full FIFO stalls unless it pops now
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    case (bus_state)
      S_WDATA:                         HREADYOUT = can_push;
      S_RD_DRAIN, S_RD_REQ, S_RD_WAIT: HREADYOUT = 1'b0;
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      S_ERR2:                          HRESP = 1'b1;
      default: ;
    endcase
  end

  // Bus FSM: address-phase capture, read sequencing and the ERROR pair
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      bus_state <= S_IDLE;
      ph_addr   <= '0;
      ph_strb   <= '0;
      HRDATA    <= '0;
    end else begin
      case (bus_state)
        S_RD_DRAIN: if (fifo_empty && be_state == BE_IDLE) bus_state <= S_RD_REQ;
        S_RD_REQ:   if (be_state == BE_REQ && req_ready) bus_state <= S_RD_WAIT;
        S_RD_WAIT: begin
          if (be_state == BE_WAIT && rsp_valid) begin
            if (rsp_error) begin
              bus_state <= S_ERR1;
            end else begin
              HRDATA    <= rsp_rdata;
              bus_state <= S_IDLE;
            end
          end
        end
        S_ERR1:     bus_state <= S_ERR2;
        default: begin
          if (HREADYOUT) begin
            if (!take_beat)   bus_state <= S_IDLE;
            else if (beat_bad) bus_state <= S_ERR1;
            else if (HWRITE)   bus_state <= S_WDATA;
            else               bus_state <= S_RD_DRAIN;
          end
        end
      endcase
      if (take_beat) begin
        ph_addr <= beat_addr;
        ph_strb <= beat_strb;
      end
    end
  end

  // Posted-write FIFO pointers and occupancy; push and pop together keep the level
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      wbuf_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   wbuf_level <= wbuf_level + LVL_W'(1);
        2'b01:   wbuf_level <= wbuf_level - LVL_W'(1);
        default: ;
      endcase
    end
  end

  // FIFO storage captures the aligned beat together with the data-phase HWDATA
  always_ff @(posedge HCLK) begin
    if (push) begin
      fifo_addr[wr_ptr] <= ph_addr;
      fifo_data[wr_ptr] <= HWDATA;
      fifo_strb[wr_ptr] <= ph_strb;
    end
  end

  // Backend engine: one outstanding request, FIFO head first, reads only once drained
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      be_state  <= BE_IDLE;
      req_valid <= 1'b0;
      req_write <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_strb  <= '0;
      wr_error  <= 1'b0;
    end else begin
      wr_error <= 1'b0;
      case (be_state)
        BE_IDLE: begin
          if (!fifo_empty) begin
            req_write <= 1'b1;
            req_addr  <= fifo_addr[rd_ptr];
            req_wdata <= fifo_data[rd_ptr];
            req_strb  <= fifo_strb[rd_ptr];
            req_valid <= 1'b1;
            be_state  <= BE_REQ;
          end else if (bus_state == S_RD_REQ) begin
            req_write <= 1'b0;
            req_addr  <= ph_addr;
            req_wdata <= '0;
            req_strb  <= ph_strb;
            req_valid <= 1'b1;
            be_state  <= BE_REQ;
          end
        end
        BE_REQ: begin
          if (req_ready) begin
            req_valid <= 1'b0;
            be_state  <= BE_WAIT;
          end
        end
        BE_WAIT: begin
          if (rsp_valid) begin
            be_state <= BE_IDLE;
            if (req_write && rsp_error) wr_error <= 1'b1;
          end
        end
        default: be_state <= BE_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_renode_ahb_subordinate_pipe.sv
// tb_renode_ahb_subordinate_pipe
// Drives the subordinate as a single AHB manager (HREADY tied to HREADYOUT) and
// models the backend as a byte-strobed memory. Expected backend requests are
// queued as stimulus is issued and compared in order as the DUT presents them.
// Honours RENODE_AHB_ALIGN_CHECK_EN the same way as the design.
module tb_renode_ahb_subordinate_pipe;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } req_t;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_strb;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        wr_error;
  logic [2:0]  wbuf_level;

  int   checks = 0;
  int   errors = 0;
  req_t exp_q[$];
  logic [31:0] mem [logic [31:0]];
  bit   err_next = 1'b0;
  int   be_latency = 1;
  bit   model_busy = 1'b0;
  int   wr_err_count = 0;

  assign HREADY = HREADYOUT;

  always #5 HCLK = ~HCLK;

  renode_ahb_subordinate_pipe #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .WBUF_DEPTH(4)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .wr_error(wr_error), .wbuf_level(wbuf_level)
  );

  // Backend model: scoreboard check on each handshake, then a timed response
  initial begin : backend_model
    req_t got;
    req_t exp;
    logic [31:0] word_addr;
    logic [31:0] rd;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_error = 1'b0;
    forever begin
      @(negedge HCLK);
      if (HRESET === 1'b0 && req_valid === 1'b1 && req_ready === 1'b1) begin
        model_busy = 1'b1;
        got = '{req_write, req_addr, (req_write ? req_wdata : 32'h0), req_strb};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL backend_req unexpected: got %h required none", got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            errors++;
            $display("[TB] FAIL backend_req got %h required %h", got, exp);
          end
        end
        word_addr = {got.addr[31:2], 2'b00};
        rd = mem.exists(word_addr) ? mem[word_addr] : (word_addr ^ 32'hA5A5_0000);
        if (got.write) begin
          for (int b = 0; b < 4; b++) if (got.strb[b]) rd[8*b +: 8] = got.wdata[8*b +: 8];
          mem[word_addr] = rd;
        end
        @(posedge HCLK);
        repeat (be_latency - 1) @(posedge HCLK);
        #1;
        rsp_valid = 1'b1;
        rsp_rdata = got.write ? 32'h0 : rd;
        rsp_error = err_next;
        err_next  = 1'b0;
        @(posedge HCLK);
        #1;
        rsp_valid = 1'b0;
        rsp_error = 1'b0;
        rsp_rdata = '0;
        model_busy = 1'b0;
      end
    end
  end

  // Count write-error pulses
  always @(negedge HCLK) if (wr_error === 1'b1) wr_err_count++;

  // Single non-pipelined transfer; returns data-phase result and wait-state count
  task automatic bus_xfer(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output logic resp, output bit saw_err1, output int waits);
    int n;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = addr; HWRITE = wr; HSIZE = size;
    n = 0;
    do begin
      @(negedge HCLK);
      n++;
    end while (HREADYOUT !== 1'b1 && n < 200);
    if (n >= 200) begin
      checks++; errors++;
      $display("[TB] FAIL addr_phase_timeout addr %h got HREADYOUT %b required 1", addr, HREADYOUT);
    end
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = wdata;
    waits = 0; saw_err1 = 1'b0;
    forever begin
      @(negedge HCLK);
      if (HREADYOUT === 1'b1) break;
      if (HRESP === 1'b1) saw_err1 = 1'b1;
      waits++;
      if (waits > 300) begin
        checks++; errors++;
        $display("[TB] FAIL data_phase_timeout addr %h got HREADYOUT %b required 1", addr, HREADYOUT);
        break;
      end
    end
    rdata = HRDATA;
    resp  = HRESP;
    @(posedge HCLK); #1;
  endtask

  // Wait until FIFO and backend are quiet
  task automatic wait_drain;
    int n;
    n = 0;
    do begin
      @(negedge HCLK);
      n++;
    end while (!(wbuf_level == 3'd0 && req_valid === 1'b0 && !model_busy && rsp_valid === 1'b0) && n < 400);
    checks++;
    if (n >= 400) begin
      errors++;
      $display("[TB] FAIL drain_timeout got level %0d req_valid %b required level 0 req_valid 0", wbuf_level, req_valid);
    end
    @(posedge HCLK); #1;
  endtask

  task automatic test_reset;
    HRESET = 1'b1;
    repeat (3) @(posedge HCLK);
    #1 HRESET = 1'b0;
    @(negedge HCLK);
    checks++;
    if ({HREADYOUT, HRESP, req_valid, wr_error} !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL reset_ctrl got rdy/resp/rv/wrerr %b required 1000", {HREADYOUT, HRESP, req_valid, wr_error});
    end
    checks++;
    if (HRDATA !== 32'h0 || wbuf_level !== 3'd0) begin
      errors++;
      $display("[TB] FAIL reset_data got HRDATA %h level %0d required 0 0", HRDATA, wbuf_level);
    end
    checks++;
    if ({req_write, req_addr, req_wdata, req_strb} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_req got %h required 0", {req_write, req_addr, req_wdata, req_strb});
    end
    @(posedge HCLK); #1;
  endtask

  task automatic test_reset_mid_read;
    logic [31:0] rdata;
    logic resp;
    bit e1;
    int w;
    req_ready = 1'b0;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HSIZE = 3'd2; HADDR = 32'h200;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    repeat (4) @(posedge HCLK);
    #1;
    @(negedge HCLK);
    checks++;
    if (HREADYOUT !== 1'b0 || req_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midread_stall got rdy %b req_valid %b required 0 1", HREADYOUT, req_valid);
    end
    @(posedge HCLK); #1 HRESET = 1'b1;
    repeat (3) @(posedge HCLK);
    #1 HRESET = 1'b0;
    @(negedge HCLK);
    checks++;
    if ({HREADYOUT, HRESP, req_valid} !== 3'b100 || wbuf_level !== 3'd0) begin
      errors++;
      $display("[TB] FAIL midread_reset got rdy/resp/rv %b level %0d required 100 0", {HREADYOUT, HRESP, req_valid}, wbuf_level);
    end
    @(posedge HCLK); #1;
    req_ready = 1'b1;
    exp_q.push_back('{1'b0, 32'h200, 32'h0, 4'hF});
    bus_xfer(1'b0, 32'h200, 3'd2, 32'h0, rdata, resp, e1, w);
    checks++;
    if (rdata !== 32'hA5A5_0200 || resp !== 1'b0) begin
      errors++;
      $display("[TB] FAIL read_after_reset got %h resp %b required a5a50200 0", rdata, resp);
    end
    wait_drain();
  endtask

  task automatic test_back_to_back;
    req_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      exp_q.push_back('{1'b1, 32'h100 + 32'(4*i), 32'hC0DE_0000 + 32'(i), 4'hF});
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HSIZE = 3'd2; HADDR = 32'h100;
    @(posedge HCLK); #1;
    for (int i = 1; i <= 4; i++) begin
      HWDATA = 32'hC0DE_0000 + 32'(i - 1);
      HADDR  = 32'h100 + 32'(4*i);
      @(negedge HCLK);
      checks++;
      if (HREADYOUT !== 1'b1) begin
        errors++;
        $display("[TB] FAIL b2b_zero_wait beat %0d got HREADYOUT %b required 1", i - 1, HREADYOUT);
      end
      @(posedge HCLK); #1;
    end
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'hC0DE_0004;
    @(negedge HCLK);
    checks++;
    if (wbuf_level !== 3'd4) begin
      errors++;
      $display("[TB] FAIL b2b_level_full got %0d required 4", wbuf_level);
    end
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    checks++;
    if (HREADYOUT !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_full_stall got HREADYOUT %b required 0", HREADYOUT);
    end
    @(posedge HCLK); #1 req_ready = 1'b1;
    @(negedge HCLK);
    checks++;
    if (HREADYOUT !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_release got HREADYOUT %b required 1", HREADYOUT);
    end
    @(posedge HCLK); #1;
    @(negedge HCLK);
    checks++;
    if (wbuf_level !== 3'd4) begin
      errors++;
      $display("[TB] FAIL b2b_push_pop_level got %0d required 4", wbuf_level);
    end
    wait_drain();
  endtask

  task automatic test_write_then_read;
    logic [31:0] rdata;
    logic resp;
    bit e1;
    int w;
    be_latency = 3;
    exp_q.push_back('{1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF});
    exp_q.push_back('{1'b0, 32'h100, 32'h0, 4'hF});
    bus_xfer(1'b1, 32'h100, 3'd2, 32'hDEAD_BEEF, rdata, resp, e1, w);
    checks++;
    if (w !== 0 || resp !== 1'b0) begin
      errors++;
      $display("[TB] FAIL posted_write got waits %0d resp %b required 0 0", w, resp);
    end
    bus_xfer(1'b0, 32'h100, 3'd2, 32'h0, rdata, resp, e1, w);
    checks++;
    if (rdata !== 32'hDEAD_BEEF || resp !== 1'b0) begin
      errors++;
      $display("[TB] FAIL read_after_write got %h resp %b required deadbeef 0", rdata, resp);
    end
    checks++;
    if (w < 5) begin
      errors++;
      $display("[TB] FAIL read_latency got %0d waits required at least 5", w);
    end
    wait_drain();
    be_latency = 1;
  endtask

  task automatic test_error_response;
    logic [31:0] rdata;
    logic resp;
    bit e1;
    int w;
    int n;
    int cnt0;
    err_next = 1'b1;
    exp_q.push_back('{1'b0, 32'h200, 32'h0, 4'hF});
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HSIZE = 3'd2; HADDR = 32'h200;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    n = 0;
    do begin
      @(negedge HCLK);
      n++;
    end while (!(HREADYOUT === 1'b0 && HRESP === 1'b1) && n < 100);
    checks++;
    if (n >= 100) begin
      errors++;
      $display("[TB] FAIL err1_seen got rdy %b resp %b required 0 1", HREADYOUT, HRESP);
    end
    @(posedge HCLK); #1;
    exp_q.push_back('{1'b0, 32'h300, 32'h0, 4'hF});
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HSIZE = 3'd2; HADDR = 32'h300;
    @(negedge HCLK);
    checks++;
    if (HREADYOUT !== 1'b1 || HRESP !== 1'b1) begin
      errors++;
      $display("[TB] FAIL err2_phase got rdy %b resp %b required 1 1", HREADYOUT, HRESP);
    end
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    n = 0;
    do begin
      @(negedge HCLK);
      n++;
    end while (HREADYOUT !== 1'b1 && n < 100);
    checks++;
    if (HRESP !== 1'b0 || HRDATA !== 32'hA5A5_0300 || n >= 100) begin
      errors++;
      $display("[TB] FAIL after_err_read got %h resp %b required a5a50300 0", HRDATA, HRESP);
    end
    @(posedge HCLK); #1;
    wait_drain();
    cnt0 = wr_err_count;
    err_next = 1'b1;
    exp_q.push_back('{1'b1, 32'h180, 32'h1234_5678, 4'hF});
    bus_xfer(1'b1, 32'h180, 3'd2, 32'h1234_5678, rdata, resp, e1, w);
    checks++;
    if (resp !== 1'b0) begin
      errors++;
      $display("[TB] FAIL posted_err_bus got resp %b required 0", resp);
    end
    wait_drain();
    checks++;
    if (wr_err_count - cnt0 != 1) begin
      errors++;
      $display("[TB] FAIL wr_error_pulse got %0d pulses required 1", wr_err_count - cnt0);
    end
  endtask

  task automatic test_strobes;
    logic [31:0] rdata;
    logic resp;
    bit e1;
    int w;
    logic [31:0] a_tab [4];
    logic [2:0]  s_tab [4];
    logic [3:0]  b_tab [4];
    a_tab = '{32'h103, 32'h102, 32'h101, 32'h100};
    s_tab = '{3'd0, 3'd1, 3'd0, 3'd1};
    b_tab = '{4'b1000, 4'b1100, 4'b0010, 4'b0011};
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{1'b1, a_tab[i], 32'h1122_3344 + 32'(i), b_tab[i]});
      bus_xfer(1'b1, a_tab[i], s_tab[i], 32'h1122_3344 + 32'(i), rdata, resp, e1, w);
      checks++;
      if (resp !== 1'b0) begin
        errors++;
        $display("[TB] FAIL strobe_write_resp idx %0d got %b required 0", i, resp);
      end
    end
    wait_drain();
  endtask

  task automatic test_align_check;
    logic [31:0] rdata;
    logic resp;
    bit e1;
    int w;
`ifdef RENODE_AHB_ALIGN_CHECK_EN
    bus_xfer(1'b1, 32'h102, 3'd2, 32'hBAD0_0001, rdata, resp, e1, w);
    checks++;
    if (resp !== 1'b1 || e1 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL misaligned_error got resp %b err1 %b required 1 1", resp, e1);
    end
    repeat (5) @(negedge HCLK);
    checks++;
    if (wbuf_level !== 3'd0 || req_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL misaligned_no_access got level %0d req_valid %b required 0 0", wbuf_level, req_valid);
    end
    @(posedge HCLK); #1;
`else
    exp_q.push_back('{1'b1, 32'h100, 32'hBAD0_0001, 4'hF});
    bus_xfer(1'b1, 32'h102, 3'd2, 32'hBAD0_0001, rdata, resp, e1, w);
    checks++;
    if (resp !== 1'b0 || e1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL misaligned_okay got resp %b err1 %b required 0 0", resp, e1);
    end
    wait_drain();
`endif
  endtask

  // Global watchdog
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired required completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    HRESET = 1'b1; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0;
    HSIZE = 3'd2; HWDATA = '0; req_ready = 1'b1;
    test_reset();
    test_reset_mid_read();
    test_back_to_back();
    test_write_then_read();
    test_error_response();
    test_strobes();
    test_align_check();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL pending_requests got %0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
